// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared FSM state type and widths for the 1:16 deserializer
package demux_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Slot filled by the bit at position sel; MSB-first order mirrors the index.
  function automatic logic [SEL_W-1:0] slot_of(input logic [SEL_W-1:0] sel,
                                               input bit lsb_first);
    return lsb_first ? sel : ~sel;
  endfunction

endpackage

// File: rtl/demux1to16_deser.sv
// rtl/demux1to16_deser.sv - serial-in, 16-bit parallel-out deserializer; optional DEMUX1TO16_DESER_PARITY_EN
module demux1to16_deser
  import demux_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              out_perr
);

`ifdef DEMUX1TO16_DESER_PARITY_EN
  localparam state_t AFTER_LAST = PARITY;
`else
  localparam state_t AFTER_LAST = HOLD;
`endif

  state_t            state, state_next;
  logic [WORD_W-1:0] data_next;
  logic [SEL_W-1:0]  slot;
  logic              collect_xfer;

  assign in_ready     = (state != HOLD);
  assign out_valid    = (state == HOLD);
  assign collect_xfer = (state == COLLECT) && in_valid;
  assign slot         = slot_of(sel, LSB_FIRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (in_valid && sel == {SEL_W{1'b1}}) state_next = AFTER_LAST;
      PARITY:  if (in_valid) state_next = HOLD;
      HOLD:    if (out_ready) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
    if (clear) state_next = COLLECT;
  end

  // 4-bit-indexed decode: only the addressed slot takes in_bit, the rest hold.
  always_comb begin
    data_next = out_data;
    for (int i = 0; i < WORD_W; i++) begin
      if (slot == SEL_W'(i)) data_next[i] = in_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= '0;
      out_data <= '0;
    end else if (clear) begin
      sel      <= '0;
      out_data <= '0;
    end else if (collect_xfer) begin
      sel      <= sel + 1'b1;
      out_data <= data_next;
    end
  end

`ifdef DEMUX1TO16_DESER_PARITY_EN
  logic par_acc;
  logic perr_q;

  // Running XOR restarts with the first bit of each word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
    end else if (clear) begin
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
    end else if (collect_xfer) begin
      par_acc <= (sel == '0) ? in_bit : (par_acc ^ in_bit);
    end else if (state == PARITY && in_valid) begin
      perr_q  <= par_acc ^ in_bit;
    end
  end

  assign out_perr = perr_q;
`else
  assign out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_demux1to16_deser.sv
// tb/tb_demux1to16_deser.sv - self-checking bench for demux1to16_deser, both slot orders
module tb_demux1to16_deser;

`ifdef DEMUX1TO16_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clear, in_bit, in_valid, out_ready;
  logic        l_in_ready, l_out_valid, l_out_perr;
  logic        m_in_ready, m_out_valid, m_out_perr;
  logic [15:0] l_out_data, m_out_data;
  logic [3:0]  l_sel, m_sel;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: bit count in current word, hold flag, both slot images.
  int          m_cnt;
  bit          m_hold;
  bit          m_par;
  bit          m_perr;
  logic [15:0] w_lsb, w_msb;

  always #5 clk = ~clk;

  demux1to16_deser #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(l_in_ready), .out_data(l_out_data), .out_valid(l_out_valid),
    .out_ready(out_ready), .sel(l_sel), .out_perr(l_out_perr));

  demux1to16_deser #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_ready(out_ready), .sel(m_sel), .out_perr(m_out_perr));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_hold = 1'b0; m_par = 1'b0; m_perr = 1'b0;
    w_lsb = '0; w_msb = '0;
  endtask

  task automatic model_update(input bit v, input bit b, input bit r, input bit c);
    if (c) begin
      model_reset();
    end else if (m_hold) begin
      if (r) begin
        m_hold = 1'b0;
        m_cnt  = 0;
      end
    end else if (v) begin
      if (m_cnt < 16) begin
        w_lsb[m_cnt]      = b;
        w_msb[15 - m_cnt] = b;
        m_par = (m_cnt == 0) ? b : (m_par ^ b);
        m_cnt++;
        if (m_cnt == 16 && !PAR_EN) m_hold = 1'b1;
      end else begin
        m_perr = m_par ^ b;
        m_hold = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_sel;
    exp_sel = 4'(m_cnt % 16);
    chk("in_ready_lsb",  {15'd0, l_in_ready},  {15'd0, !m_hold});
    chk("in_ready_msb",  {15'd0, m_in_ready},  {15'd0, !m_hold});
    chk("out_valid_lsb", {15'd0, l_out_valid}, {15'd0, m_hold});
    chk("out_valid_msb", {15'd0, m_out_valid}, {15'd0, m_hold});
    chk("sel_lsb",       {12'd0, l_sel},       {12'd0, exp_sel});
    chk("sel_msb",       {12'd0, m_sel},       {12'd0, exp_sel});
    chk("data_lsb",      l_out_data,           w_lsb);
    chk("data_msb",      m_out_data,           w_msb);
    if (m_hold) chk("perr_lsb", {15'd0, l_out_perr}, {15'd0, m_perr});
  endtask

  // Called at a falling edge; applies inputs, advances one clock, checks.
  task automatic step(input bit v, input bit b, input bit r, input bit c);
    in_valid = v; in_bit = b; out_ready = r; clear = c;
    @(posedge clk);
    model_update(v, b, r, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_word(input logic [15:0] w, input bit r, input bit pbit);
    for (int k = 0; k < 16; k++) step(1'b1, w[k], r, 1'b0);
    if (PAR_EN) step(1'b1, pbit, r, 1'b0);
  endtask

  logic [15:0] w;
  logic [15:0] rev;

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // A5C3 back-to-back with out_ready high: one valid cycle, then sel back to 0.
    w = 16'hA5C3;
    send_word(w, 1'b1, ^w);
    chk("a5c3_lsb", l_out_data, 16'hA5C3);
    chk("a5c3_msb", m_out_data, 16'hC3A5);
    chk("a5c3_valid", {15'd0, l_out_valid}, 16'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("a5c3_drop", {15'd0, l_out_valid}, 16'd0);
    chk("a5c3_sel0", {12'd0, l_sel}, 16'd0);

    // Backpressure: held word stays put while in_valid stays high.
    w = 16'h3C96;
    send_word(w, 1'b0, ^w);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, k[0], 1'b0, 1'b0);
      chk("bp_stable", l_out_data, 16'h3C96);
      chk("bp_ready", {15'd0, l_in_ready}, 16'd0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    send_word(16'h1234, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear after 7 bits, then a clean 00FF word.
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_data", l_out_data, 16'h0000);
    w = 16'h00FF;
    send_word(w, 1'b0, ^w);
    chk("clr_word", l_out_data, 16'h00FF);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-word at sel=9.
    for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_sel", {12'd0, l_sel}, 16'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel",   {12'd0, l_sel}, 16'd0);
    chk("rst_data",  l_out_data, 16'h0000);
    chk("rst_valid", {15'd0, l_out_valid}, 16'd0);
    chk("rst_perr",  {15'd0, l_out_perr}, 16'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();
    w = 16'hBEEF;
    rev = {<<{w}};
    send_word(w, 1'b1, ^w);
    chk("post_rst_lsb", l_out_data, w);
    chk("post_rst_msb", m_out_data, rev);
    step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DEMUX1TO16_DESER_PARITY_EN
    send_word(16'h0001, 1'b0, 1'b1);
    chk("par_ok", {15'd0, l_out_perr}, 16'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(16'h0001, 1'b0, 1'b0);
    chk("par_err", {15'd0, l_out_perr}, 16'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`else
    chk("perr_tied", {15'd0, l_out_perr}, 16'd0);
`endif

    // Randomized traffic with gaps, backpressure and occasional clears.
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 59) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
